// File: rtl/alu_ctrl_stage_pkg.sv
// Shared ALU control types and LEGv8 opcode constants.
// Used by the ID/EX control stage and by the execute-stage ALU.
package alu_pkg;

    typedef logic [3:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_AND   = 4'b0000;
    localparam alu_ctrl_t ALU_ORR   = 4'b0001;
    localparam alu_ctrl_t ALU_ADD   = 4'b0010;
    localparam alu_ctrl_t ALU_SUB   = 4'b0110;
    localparam alu_ctrl_t ALU_PASSB = 4'b0111;
    localparam alu_ctrl_t ALU_NOR   = 4'b1100;
    localparam alu_ctrl_t ALU_PASSA = 4'b1111;

    localparam logic [1:0] OP_MEM = 2'b00;
    localparam logic [1:0] OP_CBZ = 2'b01;
    localparam logic [1:0] OP_R   = 2'b10;
    localparam logic [1:0] OP_I   = 2'b11;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_ADDI = 11'b10010001000;
    localparam logic [10:0] OPC_SUBI = 11'b11010001000;

    typedef struct packed {
        alu_ctrl_t ctrl;
        logic      illegal;
    } dec_t;

    // I-type opcodes ignore bit 0
    function automatic logic i_match(
        input logic [10:0] opc,
        input logic [10:0] base
    );
        return opc[10:1] == base[10:1];
    endfunction

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// ID-side and EX-side handshake bundle of the ALU control stage.
// master = ID/EX neighbours, slave = the stage itself.
interface alu_ctrl_stage_if #(
    parameter int TAG_W = 5
);
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [10:0]      opcode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    alu_ctrl_t        alu_control;
    logic [TAG_W-1:0] out_tag;
    logic             illegal;

    modport master (
        output in_valid, alu_op, opcode, in_tag, out_ready,
        input  in_ready, out_valid, alu_control, out_tag, illegal
    );

    modport slave (
        input  in_valid, alu_op, opcode, in_tag, out_ready,
        output in_ready, out_valid, alu_control, out_tag, illegal
    );

endinterface

// File: rtl/alu_ctrl_stage_dec.sv
// Combinational ALUOp/opcode to ALUControl decoder.
// Shared with the single-cycle datapath.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [1:0]  alu_op,
    input  logic [10:0] opcode,
    output alu_ctrl_t   alu_control,
    output logic        illegal
);

    always_comb begin
        alu_control = ALU_PASSA;
        illegal     = 1'b1;
        unique case (1'b1)
            alu_op == OP_MEM: begin
                alu_control = ALU_ADD;
                illegal     = 1'b0;
            end
            alu_op == OP_CBZ: begin
                alu_control = ALU_PASSB;
                illegal     = 1'b0;
            end
            alu_op == OP_R && opcode == OPC_ADD: begin
                alu_control = ALU_ADD;
                illegal     = 1'b0;
            end
            alu_op == OP_R && opcode == OPC_SUB: begin
                alu_control = ALU_SUB;
                illegal     = 1'b0;
            end
            alu_op == OP_R && opcode == OPC_AND: begin
                alu_control = ALU_AND;
                illegal     = 1'b0;
            end
            alu_op == OP_R && opcode == OPC_ORR: begin
                alu_control = ALU_ORR;
                illegal     = 1'b0;
            end
            alu_op == OP_I && i_match(opcode, OPC_ADDI): begin
                alu_control = ALU_ADD;
                illegal     = 1'b0;
            end
            alu_op == OP_I && i_match(opcode, OPC_SUBI): begin
                alu_control = ALU_SUB;
                illegal     = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID/EX ALU control slot with a one-entry skid buffer.
// in_ready depends only on skid state, never on out_ready.
module alu_ctrl_stage
    import alu_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input logic              clk,
    input logic              reset,
    input logic              flush,
    alu_ctrl_stage_if.slave  bus
);

    dec_t             dec;
    alu_ctrl_t        dec_ctrl;
    logic             dec_ill;

    logic             out_v;
    logic             out_v_n;
    dec_t             out_d;
    logic [TAG_W-1:0] out_t;

    logic             skid_v;
    logic             skid_v_n;
    dec_t             skid_d;
    logic [TAG_W-1:0] skid_t;

    logic             accept;
    logic             slot_free;
    logic             from_skid;
    logic             load_out;
    logic             load_skid;

    alu_ctrl_dec u_dec (
        .alu_op      (bus.alu_op),
        .opcode      (bus.opcode),
        .alu_control (dec_ctrl),
        .illegal     (dec_ill)
    );

    assign dec = '{ctrl: dec_ctrl, illegal: dec_ill};

    always_comb begin
        accept    = bus.in_valid & ~skid_v & ~flush;
        slot_free = ~out_v | bus.out_ready;
        from_skid = slot_free & skid_v;
        load_out  = ~flush & slot_free & (skid_v | accept);
        load_skid = ~flush & ~slot_free & accept;
        // flush wins over hold; a pop in the same cycle is still consumed
        out_v_n   = load_out | (out_v & ~slot_free & ~flush);
        skid_v_n  = load_skid | (skid_v & ~slot_free & ~flush);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            out_d  <= '0;
            out_t  <= '0;
            skid_d <= '0;
            skid_t <= '0;
        end else begin
            out_v  <= out_v_n;
            skid_v <= skid_v_n;
            if (load_out) begin
                out_d <= from_skid ? skid_d : dec;
                out_t <= from_skid ? skid_t : bus.in_tag;
            end
            if (load_skid) begin
                skid_d <= dec;
                skid_t <= bus.in_tag;
            end
        end
    end

    assign bus.in_ready    = ~skid_v;
    assign bus.out_valid   = out_v;
    assign bus.alu_control = out_d.ctrl;
    assign bus.illegal     = out_d.illegal;
    assign bus.out_tag     = out_t;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed bench for alu_ctrl_stage: decode table, skid, flush,
// and asynchronous reset, with hand-computed expectations.
module tb_alu_ctrl_stage;

    logic clk;
    logic reset;
    logic flush;
    int   checks;
    int   errors;

    alu_ctrl_stage_if #(.TAG_W(5)) bus ();

    alu_ctrl_stage #(.TAG_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [10:0] opc,
                        input logic [4:0] tag);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.opcode   = opc;
        bus.in_tag   = tag;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.alu_op   = 2'b00;
        bus.opcode   = '0;
        bus.in_tag   = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  sw_op  [8];
    logic [10:0] sw_opc [8];
    logic [3:0]  sw_exp [8];

    initial begin
        checks = 0;
        errors = 0;
        sw_op[0] = 2'b10; sw_opc[0] = 11'b10001011000; sw_exp[0] = 4'b0010;
        sw_op[1] = 2'b10; sw_opc[1] = 11'b10001010000; sw_exp[1] = 4'b0000;
        sw_op[2] = 2'b10; sw_opc[2] = 11'b10101010000; sw_exp[2] = 4'b0001;
        sw_op[3] = 2'b11; sw_opc[3] = 11'b10010001000; sw_exp[3] = 4'b0010;
        sw_op[4] = 2'b11; sw_opc[4] = 11'b10010001001; sw_exp[4] = 4'b0010;
        sw_op[5] = 2'b11; sw_opc[5] = 11'b11010001001; sw_exp[5] = 4'b0110;
        sw_op[6] = 2'b00; sw_opc[6] = 11'h5a5;         sw_exp[6] = 4'b0010;
        sw_op[7] = 2'b01; sw_opc[7] = 11'h7ff;         sw_exp[7] = 4'b0111;

        reset = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        idle();
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_ctrl", 32'(bus.alu_control), 32'h0);
        check("rst_tag", 32'(bus.out_tag), 32'd0);
        check("rst_illegal", 32'(bus.illegal), 32'd0);
        reset = 1'b1;
        tick();

        // single push
        push(2'b10, 11'b11001011000, 5'd7);
        tick();
        idle();
        check("t1_valid", 32'(bus.out_valid), 32'd1);
        check("t1_ctrl", 32'(bus.alu_control), 32'h6);
        check("t1_tag", 32'(bus.out_tag), 32'd7);
        check("t1_illegal", 32'(bus.illegal), 32'd0);
        tick();
        check("t1_drain", 32'(bus.out_valid), 32'd0);

        // back-to-back decode sweep
        for (int i = 0; i < 8; i++) begin
            push(sw_op[i], sw_opc[i], 5'(i + 8));
            tick();
            check($sformatf("sw%0d_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("sw%0d_ctrl", i), 32'(bus.alu_control),
                  32'(sw_exp[i]));
            check($sformatf("sw%0d_tag", i), 32'(bus.out_tag), 32'(i + 8));
            check($sformatf("sw%0d_ill", i), 32'(bus.illegal), 32'd0);
        end
        idle();
        tick();
        check("sw_drain", 32'(bus.out_valid), 32'd0);

        // illegal decodes
        push(2'b10, 11'b11111111111, 5'd3);
        tick();
        check("ill_r_ctrl", 32'(bus.alu_control), 32'hf);
        check("ill_r_flag", 32'(bus.illegal), 32'd1);
        push(2'b11, 11'b10001011000, 5'd4);
        tick();
        idle();
        check("ill_i_ctrl", 32'(bus.alu_control), 32'hf);
        check("ill_i_flag", 32'(bus.illegal), 32'd1);
        check("ill_i_tag", 32'(bus.out_tag), 32'd4);
        tick();

        // back-pressure and skid
        bus.out_ready = 1'b0;
        push(2'b10, 11'b10001011000, 5'd1);
        tick();
        check("bp1_tag", 32'(bus.out_tag), 32'd1);
        check("bp1_ready", 32'(bus.in_ready), 32'd1);
        push(2'b10, 11'b11001011000, 5'd2);
        tick();
        check("bp2_hold_tag", 32'(bus.out_tag), 32'd1);
        check("bp2_hold_ctrl", 32'(bus.alu_control), 32'h2);
        check("bp2_ready", 32'(bus.in_ready), 32'd0);
        push(2'b10, 11'b10001010000, 5'd3);
        tick();
        idle();
        check("bp3_hold_tag", 32'(bus.out_tag), 32'd1);
        check("bp3_valid", 32'(bus.out_valid), 32'd1);
        check("bp3_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        check("bp4_tag", 32'(bus.out_tag), 32'd2);
        check("bp4_ctrl", 32'(bus.alu_control), 32'h6);
        check("bp4_valid", 32'(bus.out_valid), 32'd1);
        check("bp4_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("bp5_empty", 32'(bus.out_valid), 32'd0);
        tick();
        check("bp6_no_tag3", 32'(bus.out_valid), 32'd0);

        // flush with both entries full
        bus.out_ready = 1'b0;
        push(2'b10, 11'b10001011000, 5'd10);
        tick();
        push(2'b10, 11'b10001011000, 5'd11);
        tick();
        check("fl_full", 32'(bus.in_ready), 32'd0);
        flush = 1'b1;
        push(2'b10, 11'b10001011000, 5'd12);
        tick();
        flush = 1'b0;
        idle();
        check("fl_valid", 32'(bus.out_valid), 32'd0);
        check("fl_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        check("fl_drop1", 32'(bus.out_valid), 32'd0);
        tick();
        check("fl_drop2", 32'(bus.out_valid), 32'd0);

        // async reset mid-stall
        bus.out_ready = 1'b0;
        push(2'b10, 11'b10101010000, 5'd20);
        tick();
        push(2'b10, 11'b10101010000, 5'd21);
        tick();
        idle();
        check("ar_pre_ready", 32'(bus.in_ready), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("ar_valid", 32'(bus.out_valid), 32'd0);
        check("ar_ready", 32'(bus.in_ready), 32'd1);
        check("ar_ctrl", 32'(bus.alu_control), 32'h0);
        check("ar_tag", 32'(bus.out_tag), 32'd0);
        #1;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        push(2'b10, 11'b11001011000, 5'd7);
        tick();
        idle();
        check("ar_push_valid", 32'(bus.out_valid), 32'd1);
        check("ar_push_ctrl", 32'(bus.alu_control), 32'h6);
        check("ar_push_tag", 32'(bus.out_tag), 32'd7);
        tick();
        check("ar_push_drain", 32'(bus.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
- Produces the 4-bit ALUControl word that drives the 64-bit execute-stage ALU. It decodes the main decoder's ALUOp and the LEGv8 instruction opcode field.
- Registers the result into an ID/EX control slot with a valid/ready handshake. A one-entry skid buffer lets back-pressure from EX stall ID without a combinational ready path.
- Carries a per-instruction tag alongside the control word so the ALU result can be matched to its destination.

Parameters:
- TAG_W, 5, width of the passthrough tag (destination register index).

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  ID offers a decoded instruction
- in_ready  out  1  stage can accept; in_ready = ~skid_valid (registered, no comb path from out_ready)
- alu_op  in  2  main-decoder ALUOp
- opcode  in  11  instr[31:21]
- in_tag  in  TAG_W  passthrough tag
- flush  in  1  branch-mispredict squash, synchronous
- out_valid  out  1  ALUControl slot valid toward EX
- out_ready  in  1  EX accepts
- alu_control  out  4  ALU operation select
- out_tag  out  TAG_W  tag of the presented entry
- illegal  out  1  presented entry had an undecodable opcode

Behaviour:
- Reset (reset=0, async): out_valid=0, skid_valid=0, so in_ready=1; alu_control=4'b0000, out_tag=0, illegal=0. All data registers are cleared.
- Decode (combinational, before registering):
  - alu_op 00 -> 0010 (add, LDUR/STUR address)
  - alu_op 01 -> 0111 (pass b, CBZ)
  - alu_op 10 (R-type):
    - 10001011000 ADD -> 0010
    - 11001011000 SUB -> 0110
    - 10001010000 AND -> 0000
    - 10101010000 ORR -> 0001
  - alu_op 11 (I-type; opcode[0] is don't-care):
    - 1001000100x ADDI -> 0010
    - 1101000100x SUBI -> 0110
  - Any other combination -> alu_control=1111 (ALU passes a), illegal=1.
- Accept: in_valid & in_ready & ~flush.
- Output slot:
  - If empty, or out_ready=1 this cycle, the slot loads from skid if skid_valid, else from an accepted input.
  - If the slot is full and out_ready=0, an accepted input goes to skid.
- Latency:
  - Input accepted at edge N is presented at out_valid after edge N when the pipe is empty (1 cycle).
  - Throughput is 1/cycle while out_ready=1.
- Stall: out_valid=1, out_ready=0 holds alu_control, out_tag and illegal stable. At most one extra entry is absorbed into skid, after which in_ready=0.
- Simultaneous pop and push with skid empty: the new entry goes straight to the output slot and skid stays empty.
- Simultaneous pop with skid full: skid moves to the output slot and in_ready rises the next cycle.
- Flush:
  - Highest priority. At the edge, out_valid and skid_valid both clear.
  - An input offered in the flush cycle is dropped.
  - A pop with out_ready=1 in that cycle still counts as consumed by EX.
  - Data registers may keep stale values.
- Reset mid-operation discards both entries immediately (async); after release, behaviour is as after power-up.
- Data registers load only when their valid is being set. No X propagation from idle inputs into valid.

Decomposition:
- Shared package alu_pkg:
  - typedef alu_ctrl_t (logic [3:0]) with constants ALU_AND=0000, ALU_ORR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_PASSB=0111, ALU_NOR=1100, ALU_PASSA=1111.
  - ALUOp constants OP_MEM=00, OP_CBZ=01, OP_R=10, OP_I=11.
  - 11-bit opcode constants for ADD/SUB/AND/ORR/ADDI/SUBI.
  - The same package is imported by the ALU.
- One sub-module: alu_ctrl_dec, the combinational decode ({alu_op, opcode} -> {alu_control, illegal}), reused by the single-cycle datapath.

Test Plan:
1. Reset then single push: alu_op=10, opcode=11001011000, tag=7, out_ready=1 -> the next cycle shows out_valid=1, alu_control=0110, out_tag=7, illegal=0; the following cycle out_valid=0.
2. Decode sweep at 1/cycle with out_ready=1: ADD/AND/ORR/ADDI(both opcode[0] values)/SUBI, alu_op 00 and 01 -> the respective outputs are 0010, 0000, 0001, 0010, 0010, 0110, 0010, 0111, in order, with no bubbles.
3. Illegal decode: alu_op=10, opcode=11111111111 -> alu_control=1111, illegal=1.
4. Back-pressure: out_ready=0 with pushes of tags 1, 2, 3 on consecutive cycles:
   - tag 1 is presented and held; tag 2 goes to skid; in_ready=0 so tag 3 is not accepted.
   - Raising out_ready yields tag 1 then tag 2, and in_ready returns to 1 one cycle after tag 1 pops.
5. Flush with slot and skid both full: both entries are lost; the next cycle has out_valid=0 and in_ready=1; an input offered in the flush cycle never appears.
6. Async reset asserted mid-stall, between clock edges -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge; a subsequent push behaves as in test 1.
